// File: rtl/flow_pkg.sv
// rtl/flow_pkg.sv - shared constants and debounce state encoding for the key/flow controller
package flow_pkg;

  localparam int KEY_RUN    = 0;
  localparam int KEY_DIR    = 1;
  localparam int KEY_SPD_UP = 2;
  localparam int KEY_SPD_DN = 3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic [1:0] SPD_MIN = 2'd0;
  localparam logic [1:0] SPD_MAX = 2'd3;

  typedef enum logic [1:0] {
    DEB_IDLE    = 2'd0,
    DEB_FILT_DN = 2'd1,
    DEB_DOWN    = 2'd2,
    DEB_FILT_UP = 2'd3
  } deb_state_e;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one active-low key: 2-flop sync, debounce FSM, press pulse
module key_debounce
  import flow_pkg::*;
#(
  parameter logic [19:0] DEB_MAX = 20'd999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_i,
  output logic level_o,
  output logic press_o
);

  logic        sync1_q, sync2_q;
  deb_state_e  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        level_q, level_d;
  logic        press_q, press_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= DEB_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  // The sample must stay stable for DEB_MAX+1 consecutive cycles to change level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    case (state_q)
      DEB_IDLE: begin
        if (!sync2_q) begin
          state_d = DEB_FILT_DN;
          cnt_d   = 20'd1;
        end
      end
      DEB_FILT_DN: begin
        if (sync2_q) begin
          state_d = DEB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_MAX) begin
          state_d = DEB_DOWN;
          cnt_d   = '0;
          level_d = 1'b0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      DEB_DOWN: begin
        if (sync2_q) begin
          state_d = DEB_FILT_UP;
          cnt_d   = 20'd1;
        end
      end
      DEB_FILT_UP: begin
        if (!sync2_q) begin
          state_d = DEB_DOWN;
          cnt_d   = '0;
        end else if (cnt_q == DEB_MAX) begin
          state_d = DEB_IDLE;
          cnt_d   = '0;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: begin
        state_d = DEB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/key_flow_ctrl.sv
// rtl/key_flow_ctrl.sv - debounced key inputs driving run/dir/speed state and the LED step tick
module key_flow_ctrl
  import flow_pkg::*;
#(
  parameter logic [19:0] DEB_MAX  = 20'd999_999,
  parameter logic [24:0] BASE_MAX = 25'd24_999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] key_in,
  output logic [3:0] key_level,
  output logic [3:0] key_press,
  output logic       run_en,
  output logic       dir,
  output logic [1:0] speed_sel,
  output logic       step_flag
);

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEB_MAX (DEB_MAX)
    ) u_deb (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key_i     (key_in[i]),
      .level_o   (key_level[i]),
      .press_o   (key_press[i])
    );
  end

  logic        run_en_q, run_en_d;
  logic        dir_q, dir_d;
  logic [1:0]  speed_q, speed_d;
  logic [24:0] step_cnt_q, step_cnt_d;
  logic        step_flag_q, step_flag_d;
  logic [24:0] limit;
  logic        spd_up, spd_dn;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      run_en_q    <= 1'b1;
      dir_q       <= DIR_LEFT;
      speed_q     <= SPD_MIN;
      step_cnt_q  <= '0;
      step_flag_q <= 1'b0;
    end else begin
      run_en_q    <= run_en_d;
      dir_q       <= dir_d;
      speed_q     <= speed_d;
      step_cnt_q  <= step_cnt_d;
      step_flag_q <= step_flag_d;
    end
  end

  assign spd_up = key_press[KEY_SPD_UP];
  assign spd_dn = key_press[KEY_SPD_DN];
  assign limit  = BASE_MAX >> speed_q;

  always_comb begin
    run_en_d = run_en_q ^ key_press[KEY_RUN];
    dir_d    = dir_q;
    if (key_press[KEY_DIR]) begin
      dir_d = (dir_q == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
    end
    // Simultaneous up and down presses cancel out.
    speed_d = speed_q;
    if (spd_up && !spd_dn && speed_q != SPD_MAX) begin
      speed_d = speed_q + 2'd1;
    end else if (spd_dn && !spd_up && speed_q != SPD_MIN) begin
      speed_d = speed_q - 2'd1;
    end
  end

  // A speed-up can leave the count past the new limit; restart silently rather than overflow.
  always_comb begin
    step_cnt_d  = step_cnt_q;
    step_flag_d = 1'b0;
    if (run_en_q) begin
      if (step_cnt_q > limit) begin
        step_cnt_d = '0;
      end else if (step_cnt_q == limit) begin
        step_cnt_d  = '0;
        step_flag_d = 1'b1;
      end else begin
        step_cnt_d = step_cnt_q + 25'd1;
      end
    end
  end

  assign run_en    = run_en_q;
  assign dir       = dir_q;
  assign speed_sel = speed_q;
  assign step_flag = step_flag_q;

endmodule

// File: tb/tb_key_flow_ctrl.sv
// tb/tb_key_flow_ctrl.sv - directed self-checking bench for key_flow_ctrl
module tb_key_flow_ctrl;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [3:0] key_in;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic       run_en;
  logic       dir;
  logic [1:0] speed_sel;
  logic       step_flag;

  int total;
  int bad;
  int flag_cnt;
  logic [3:0] press_acc;

  key_flow_ctrl #(
    .DEB_MAX  (20'd4),
    .BASE_MAX (25'd15)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_in),
    .key_level (key_level),
    .key_press (key_press),
    .run_en    (run_en),
    .dir       (dir),
    .speed_sel (speed_sel),
    .step_flag (step_flag)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    press_acc = press_acc | key_press;
    flag_cnt  = flag_cnt + int'(step_flag);
  endtask

  task automatic wait_press(input int idx, output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (key_press[idx]) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_flag(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (step_flag) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic measure_period(output int p);
    int n;
    wait_flag(n);
    if (n < 0) p = -1;
    else wait_flag(p);
  endtask

  task automatic press_key(input int idx, input int hold);
    key_in[idx] = 1'b0;
    repeat (hold) tick();
    key_in[idx] = 1'b1;
    repeat (12) tick();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_level"}, int'(key_level), 15);
    chk({tag, "_press"}, int'(key_press), 0);
    chk({tag, "_run"}, int'(run_en), 1);
    chk({tag, "_dir"}, int'(dir), 0);
    chk({tag, "_spd"}, int'(speed_sel), 0);
    chk({tag, "_flag"}, int'(step_flag), 0);
  endtask

  initial begin
    int n;
    int p;
    int exp_spd [4] = '{1, 2, 3, 3};
    int exp_per [4] = '{8, 4, 2, 2};
    total     = 0;
    bad       = 0;
    flag_cnt  = 0;
    press_acc = '0;
    sys_rst_n = 1'b0;
    key_in    = 4'hF;

    // 1: reset values and free-running step tick at speed 0
    repeat (3) tick();
    check_reset_vals("rst");
    sys_rst_n = 1'b1;
    flag_cnt  = 0;
    press_acc = '0;
    repeat (40) tick();
    chk("t1_flags40", flag_cnt, 2);
    chk("t1_press_none", int'(press_acc), 0);
    chk("t1_level", int'(key_level), 15);
    measure_period(p);
    chk("t1_period", p, 16);

    // 2: short glitches are rejected, a held key pulses once after 7 cycles
    press_acc = '0;
    for (int r = 0; r < 3; r++) begin
      key_in[0] = 1'b0;
      repeat (3) tick();
      key_in[0] = 1'b1;
      repeat (4) tick();
    end
    repeat (8) tick();
    chk("t2_glitch_press", int'(press_acc), 0);
    chk("t2_glitch_run", int'(run_en), 1);
    key_in[0] = 1'b0;
    wait_press(0, n);
    chk("t2_latency", n, 7);
    chk("t2_level_low", int'(key_level), 14);
    tick();
    chk("t2_pulse_width", int'(key_press), 0);
    chk("t2_run_off", int'(run_en), 0);
    flag_cnt = 0;
    repeat (40) tick();
    chk("t2_no_flags", flag_cnt, 0);
    key_in[0] = 1'b1;
    repeat (12) tick();
    chk("t2_release_run", int'(run_en), 0);
    chk("t2_release_level", int'(key_level), 15);
    press_key(0, 10);
    chk("t2_run_on", int'(run_en), 1);

    // 3: speed up with saturation
    for (int k = 0; k < 4; k++) begin
      press_key(2, 10);
      chk($sformatf("t3_spd%0d", k), int'(speed_sel), exp_spd[k]);
      measure_period(p);
      chk($sformatf("t3_per%0d", k), p, exp_per[k]);
    end

    // 4: up and down together cancel; then down to the floor
    key_in[3:2] = 2'b00;
    wait_press(2, n);
    chk("t4_latency", n, 7);
    chk("t4_both", int'(key_press[3:2]), 3);
    key_in[3:2] = 2'b11;
    repeat (12) tick();
    chk("t4_spd_same", int'(speed_sel), 3);
    for (int k = 0; k < 4; k++) begin
      press_key(3, 10);
      chk($sformatf("t4_dn%0d", k), int'(speed_sel), (k < 3) ? 2 - k : 0);
    end
    chk("t4_run", int'(run_en), 1);

    // 5: two quick speed-ups leave step_cnt past limit 3; it clears with no tick
    wait_flag(n);
    chk("t5_sync_flag", int'(n > 0), 1);
    repeat (10) tick();
    key_in[2] = 1'b0;
    repeat (5) tick();
    key_in[2] = 1'b1;
    repeat (5) tick();
    key_in[2] = 1'b0;
    repeat (5) tick();
    key_in[2] = 1'b1;
    wait_flag(n);
    chk("t5_first_flag", n, 8);
    chk("t5_spd", int'(speed_sel), 2);
    wait_flag(p);
    chk("t5_period", p, 4);

    // 6: reset while a key is held; it must re-qualify after release
    key_in[1] = 1'b0;
    repeat (5) tick();
    sys_rst_n = 1'b0;
    #1;
    check_reset_vals("t6_rst");
    tick();
    tick();
    sys_rst_n = 1'b1;
    wait_press(1, n);
    chk("t6_latency", n, 7);
    tick();
    chk("t6_dir", int'(dir), 1);
    chk("t6_single", int'(key_press), 0);
    key_in[1] = 1'b1;
    repeat (12) tick();
    chk("t6_dir_hold", int'(dir), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
